bullcow_display: RTL and testbench

- Downstream presentation stage for the Bulls & Cows game FSM.
- Consumes the game FSM's state, score and result outputs and drives an 8-digit multiplexed seven-segment display. Anodes and segments are active-low.
- Shows state prompts during play, a timed bull/cow result after each confirmed guess, and both scores at end of game.
- Digit 7 is leftmost; digit 0 is rightmost.

---
 rtl/bullcow_display_if.sv | 39 +++
 rtl/bullcow_display.sv | 224 ++++++++++++++++++++++
 tb/tb_bullcow_display.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bullcow_display_if.sv
// -----------------------------------------------------------------------------
// bullcow_display_if
// Interface carrying the Bulls & Cows game FSM outputs that the display stage
// presents.
//   game_state      : game FSM state (000 J1_SETUP, 001 J2_SETUP, 010 J1_GUESS,
//                     011 J2_GUESS, 111 END_GAME)
//   guess_confirmed : level; a rising edge marks a new guess result
//   bull_count      : bulls of the last guess (0..4)
//   cow_count       : cows of the last guess (0..4)
//   J1_points       : player 1 score (0..255)
//   J2_points       : player 2 score (0..255)
// Modports: master = game FSM side (drives), slave = display side (reads).
// -----------------------------------------------------------------------------
interface bullcow_display_if;
  logic [2:0] game_state;
  logic       guess_confirmed;
  logic [2:0] bull_count;
  logic [2:0] cow_count;
  logic [7:0] J1_points;
  logic [7:0] J2_points;

  modport master (
    output game_state,
    output guess_confirmed,
    output bull_count,
    output cow_count,
    output J1_points,
    output J2_points
  );

  modport slave (
    input game_state,
    input guess_confirmed,
    input bull_count,
    input cow_count,
    input J1_points,
    input J2_points
  );
endinterface

// File: rtl/bullcow_display.sv
// -----------------------------------------------------------------------------
// bullcow_display
// Presentation stage for the Bulls & Cows game. Drives an 8-digit multiplexed
// seven-segment display (active-low anodes and segments). Shows state prompts
// during play, a timed bull/cow result after each confirmed guess, and both
// scores once the game has ended. Digit 7 is the leftmost digit.
//
// Parameters:
//   REFRESH_DIV : cycles each digit stays lit before the scan advances (>= 2)
//   HOLD_CYCLES : cycles the bull/cow result stays on screen (>= 1)
// Ports:
//   clock     : system clock
//   reset     : synchronous, active-high
//   game      : game FSM outputs (slave modport of bullcow_display_if)
//   an        : digit enables, active-low, one-hot-low (registered)
//   dec_cat   : segments {dp,g,f,e,d,c,b,a}, active-low, dp always off
//               (registered together with an)
//   disp_mode : 00 STATE, 01 RESULT, 10 SCORE
// -----------------------------------------------------------------------------
module bullcow_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_CYCLES = 200000000
) (
  input  logic               clock,
  input  logic               reset,
  bullcow_display_if.slave   game,
  output logic [7:0]         an,
  output logic [7:0]         dec_cat,
  output logic [1:0]         disp_mode
);

  // Counter widths: hold spans 0..HOLD_CYCLES-1, refresh spans 0..REFRESH_DIV-1.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RW = $clog2(REFRESH_DIV);

  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

  // Glyphs, bits 6..0 = g,f,e,d,c,b,a, active-low.
  localparam logic [6:0] SEG_J     = 7'h61;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h27;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] GS_J1_SETUP = 3'b000;
  localparam logic [2:0] GS_J2_SETUP = 3'b001;
  localparam logic [2:0] GS_J1_GUESS = 3'b010;
  localparam logic [2:0] GS_J2_GUESS = 3'b011;
  localparam logic [2:0] GS_END_GAME = 3'b111;

  typedef enum logic [1:0] {
    MODE_STATE  = 2'b00,
    MODE_RESULT = 2'b01,
    MODE_SCORE  = 2'b10
  } mode_e;

  // Decimal digit to glyph; anything outside 0..9 shows a dash.
  function automatic logic [6:0] digit_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // 8-bit binary to three BCD digits {hundreds, tens, units} (double dabble).
  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [19:0] sr;
    sr = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
    return sr[19:8];
  endfunction

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_e         mode_q, mode_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          gc_prev_q;
  logic          gc_rise;

  // gc_prev clears on reset, so a level already high on the first free-running
  // cycle is treated as a fresh guess.
  assign gc_rise = game.guess_confirmed & ~gc_prev_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= MODE_STATE;
      hold_q    <= '0;
      gc_prev_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      gc_prev_q <= game.guess_confirmed;
    end
  end

  // Next-state logic, priority top-down. The hold is loaded with
  // HOLD_CYCLES-1 and RESULT exits on the cycle it reads zero, so RESULT is
  // visible for exactly HOLD_CYCLES cycles.
  always_comb begin
    mode_d = mode_q;
    hold_d = hold_q;
    if (game.game_state == GS_END_GAME) begin
      mode_d = MODE_SCORE;
      hold_d = '0;
    end else if (gc_rise) begin
      mode_d = MODE_RESULT;
      hold_d = HOLD_MAX;
    end else if (mode_q == MODE_RESULT && hold_q == '0) begin
      mode_d = MODE_STATE;
    end else if (mode_q == MODE_RESULT) begin
      hold_d = hold_q - HW'(1);
    end else if (mode_q == MODE_SCORE) begin
      mode_d = MODE_STATE;
    end
  end

  // Output logic: mode report and per-digit glyph contents.
  logic [6:0]  digit_glyph [8];
  logic [11:0] j1_bcd;
  logic [11:0] j2_bcd;

  assign j1_bcd = to_bcd(game.J1_points);
  assign j2_bcd = to_bcd(game.J2_points);

  always_comb begin
    disp_mode = mode_q;
    for (int i = 0; i < 8; i++) begin
      digit_glyph[i] = SEG_BLANK;
    end
    case (mode_q)
      MODE_STATE: begin
        case (game.game_state)
          GS_J1_SETUP, GS_J2_SETUP: begin
            digit_glyph[7] = SEG_J;
            digit_glyph[6] = (game.game_state == GS_J1_SETUP) ? digit_seg(4'd1)
                                                              : digit_seg(4'd2);
            digit_glyph[2] = SEG_S;
            digit_glyph[1] = SEG_E;
            digit_glyph[0] = SEG_T;
          end
          GS_J1_GUESS, GS_J2_GUESS: begin
            digit_glyph[7] = SEG_J;
            digit_glyph[6] = (game.game_state == GS_J1_GUESS) ? digit_seg(4'd1)
                                                              : digit_seg(4'd2);
            digit_glyph[1] = SEG_G;
            digit_glyph[0] = SEG_O;
          end
          default: ;
        endcase
      end
      MODE_RESULT: begin
        // Counts are shown live, so a late count update is still displayed.
        digit_glyph[7] = SEG_B;
        digit_glyph[6] = digit_seg({1'b0, game.bull_count});
        digit_glyph[3] = SEG_C;
        digit_glyph[2] = digit_seg({1'b0, game.cow_count});
      end
      MODE_SCORE: begin
        digit_glyph[7] = digit_seg(j1_bcd[11:8]);
        digit_glyph[6] = digit_seg(j1_bcd[7:4]);
        digit_glyph[5] = digit_seg(j1_bcd[3:0]);
        digit_glyph[2] = digit_seg(j2_bcd[11:8]);
        digit_glyph[1] = digit_seg(j2_bcd[7:4]);
        digit_glyph[0] = digit_seg(j2_bcd[3:0]);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan: anode and segment registers are loaded from the same index on the
  // same edge, so a lit digit never shows a neighbour's segments.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] refresh_q;
  logic [2:0]    idx_q;
  logic [7:0]    an_q;
  logic [7:0]    dec_cat_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= 3'd0;
      an_q      <= 8'hFF;
      dec_cat_q <= 8'hFF;
    end else begin
      an_q      <= ~(8'b1 << idx_q);
      dec_cat_q <= {1'b1, digit_glyph[idx_q]};
      if (refresh_q == REFRESH_MAX) begin
        refresh_q <= '0;
        idx_q     <= idx_q + 3'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
    end
  end

  assign an      = an_q;
  assign dec_cat = dec_cat_q;

endmodule

// File: tb/tb_bullcow_display.sv
// -----------------------------------------------------------------------------
// tb_bullcow_display
// Self-checking bench for bullcow_display with REFRESH_DIV=4, HOLD_CYCLES=10.
// A behavioural model tracks the display mode from the game rules, derives the
// lit digit from the number of cycles since reset, and renders each digit as a
// character before looking up its segment pattern.
// -----------------------------------------------------------------------------
module tb_bullcow_display;

  localparam int RD   = 4;
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] an;
  logic [7:0] dec_cat;
  logic [1:0] disp_mode;

  bullcow_display_if gif ();

  bullcow_display #(
    .REFRESH_DIV (RD),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .game      (gif.slave),
    .an        (an),
    .dec_cat   (dec_cat),
    .disp_mode (disp_mode)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: mode 0=STATE 1=RESULT 2=SCORE, remaining result cycles,
  // previous guess_confirmed, cycles since reset release.
  int m_mode   = 0;
  int m_rem    = 0;
  bit m_gcprev = 1'b0;
  int m_k      = 0;

  function automatic logic [6:0] seg_of(input byte ch);
    case (ch)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "J": return 7'h61;
      "S": return 7'h12;
      "E": return 7'h06;
      "t": return 7'h07;
      "G": return 7'h42;
      "O": return 7'h40;
      "b": return 7'h03;
      "c": return 7'h27;
      "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic byte num_char(input int n);
    if (n > 9) return "-";
    return byte'(8'h30 + n);
  endfunction

  // Character shown on digit d (7 = leftmost) for a given mode and the
  // current game inputs.
  function automatic byte char_at(input int mode, input int d);
    byte c [8];
    int  j1;
    int  j2;
    for (int i = 0; i < 8; i++) c[i] = " ";
    j1 = int'(gif.J1_points);
    j2 = int'(gif.J2_points);
    if (mode == 1) begin
      c[7] = "b"; c[6] = num_char(int'(gif.bull_count));
      c[3] = "c"; c[2] = num_char(int'(gif.cow_count));
    end else if (mode == 2) begin
      c[7] = num_char(j1 / 100); c[6] = num_char((j1 / 10) % 10); c[5] = num_char(j1 % 10);
      c[2] = num_char(j2 / 100); c[1] = num_char((j2 / 10) % 10); c[0] = num_char(j2 % 10);
    end else begin
      case (gif.game_state)
        3'b000: begin c[7]="J"; c[6]="1"; c[2]="S"; c[1]="E"; c[0]="t"; end
        3'b001: begin c[7]="J"; c[6]="2"; c[2]="S"; c[1]="E"; c[0]="t"; end
        3'b010: begin c[7]="J"; c[6]="1"; c[1]="G"; c[0]="O"; end
        3'b011: begin c[7]="J"; c[6]="2"; c[1]="G"; c[0]="O"; end
        default: ;
      endcase
    end
    return c[d];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, m_k);
    end
  endtask

  // Predict the outputs of the next clock edge from the current inputs, apply
  // the edge, then compare just after it.
  task automatic step();
    logic [7:0] e_an;
    logic [7:0] e_dc;
    logic [1:0] e_md;
    int         idx;
    bit         rise;
    if (reset) begin
      e_an = 8'hFF; e_dc = 8'hFF; e_md = 2'b00;
      m_mode = 0; m_rem = 0; m_gcprev = 1'b0; m_k = 0;
    end else begin
      m_k++;
      idx  = ((m_k - 1) / RD) % 8;
      e_an = ~(8'h01 << idx);
      e_dc = {1'b1, seg_of(char_at(m_mode, idx))};
      rise = gif.guess_confirmed && !m_gcprev;
      if (gif.game_state == 3'b111) begin
        m_mode = 2; m_rem = 0;
      end else if (rise) begin
        m_mode = 1; m_rem = HOLD;
      end else if (m_mode == 1) begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
      m_gcprev = gif.guess_confirmed;
      e_md = 2'(m_mode);
    end
    @(posedge clk);
    #1;
    check("an", an, e_an);
    check("dec_cat", dec_cat, e_dc);
    check("disp_mode", {6'd0, disp_mode}, {6'd0, e_md});
  endtask

  initial begin
    int sel;
    reset               = 1'b1;
    gif.game_state      = 3'b000;
    gif.guess_confirmed = 1'b0;
    gif.bull_count      = 3'd0;
    gif.cow_count       = 3'd0;
    gif.J1_points       = 8'd0;
    gif.J2_points       = 8'd0;

    // Reset values, then a full scan of the J1 setup prompt.
    step(); step();
    reset = 1'b0;
    repeat (36) step();
    $display("scan J1 setup prompt done at cycle %0d", m_k);

    // First guess: 2 bulls, 1 cow; re-trigger 5 cycles into RESULT.
    gif.game_state = 3'b010; gif.bull_count = 3'd2; gif.cow_count = 3'd1;
    step();
    gif.guess_confirmed = 1'b1; step();
    gif.guess_confirmed = 1'b0; repeat (4) step();
    gif.guess_confirmed = 1'b1; step();
    gif.guess_confirmed = 1'b0; repeat (18) step();
    $display("result hold and restart done at cycle %0d", m_k);

    // Randomised guesses with random counts and gaps.
    repeat (8) begin
      gif.game_state = 3'($urandom_range(2, 3));
      gif.bull_count = 3'($urandom_range(0, 4));
      gif.cow_count  = 3'($urandom_range(0, 4));
      gif.guess_confirmed = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      gif.guess_confirmed = 1'b0;
      repeat ($urandom_range(3, 20)) step();
    end

    // End of game entered while a result is on screen.
    gif.guess_confirmed = 1'b1; step();
    gif.guess_confirmed = 1'b0; repeat (2) step();
    gif.game_state = 3'b111; gif.J1_points = 8'd7; gif.J2_points = 8'd200;
    repeat (40) step();
    repeat (3) begin
      gif.J1_points = 8'($urandom_range(0, 255));
      gif.J2_points = 8'($urandom_range(0, 255));
      repeat (34) step();
    end
    $display("score display done at cycle %0d", m_k);

    // Undefined game state blanks every digit while scanning continues.
    gif.game_state = 3'b101;
    repeat (34) step();

    // Reset during RESULT and mid-scan, then scanning restarts at digit 0.
    gif.game_state = 3'b011;
    gif.guess_confirmed = 1'b1;
    repeat (7) step();
    reset = 1'b1; step();
    reset = 1'b0; gif.guess_confirmed = 1'b0;
    repeat (20) step();
    $display("reset abort done at cycle %0d", m_k);

    // Random soak over all inputs, with occasional resets.
    repeat (400) begin
      sel = $urandom_range(0, 5);
      gif.game_state = (sel < 4) ? 3'(sel) : ((sel == 4) ? 3'b111 : 3'b101);
      if ($urandom_range(0, 3) == 0) gif.guess_confirmed = ~gif.guess_confirmed;
      gif.bull_count = 3'($urandom_range(0, 7));
      gif.cow_count  = 3'($urandom_range(0, 7));
      gif.J1_points  = 8'($urandom_range(0, 255));
      gif.J2_points  = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 99) == 0);
      repeat ($urandom_range(1, 6)) step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
